// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding and button-path constants for the clock controller
// Contents: clk_mode_e, SYNC_LAT (button-to-command latency), next_mode() helper
package clock_pkg;
   typedef enum logic [1:0] {
      MODE_RUN     = 2'd0,
      MODE_SET_MIN = 2'd1,
      MODE_SET_SEC = 2'd2
   } clk_mode_e;
   localparam int SYNC_LAT = 3;
   // Illegal encodings fall back to RUN.
   function automatic clk_mode_e next_mode(input clk_mode_e m);
      return (m == MODE_RUN) ? MODE_SET_MIN : (m == MODE_SET_MIN) ? MODE_SET_SEC : MODE_RUN;
   endfunction
endpackage

// File: rtl/clock_btn_sync.sv
// clock_btn_sync: button synchroniser, rising-edge pulse and optional hold-to-repeat
// Ports: clk; rst (async, active high); btn (raw debounced level);
//        clr (drops repeat state and swallows the pulse being formed);
//        pulse (one-cycle registered press/repeat pulse)
module clock_btn_sync
   import clock_pkg::*;
#(
   parameter bit REPEAT_EN  = 1'b0,
   parameter int HOLD_CYC   = 25_000_000,
   parameter int REPEAT_CYC = 5_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   input  logic clr,
   output logic pulse
);
   localparam int MAXC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int W = $clog2(MAXC);
   localparam logic [W-1:0] HOLD_END = W'(HOLD_CYC - 1);
   localparam logic [W-1:0] REP_END = W'(REPEAT_CYC - 1);
   logic sync1_q, sync2_q, hist_q, hist_d, pulse_q, pulse_d, arm_q, arm_d, rep_q, rep_d;
   logic rise, fire;
   logic [SYNC_LAT-2:0] fill_q, fill_d;
   logic [W-1:0] cnt_q, cnt_d;
   always_comb begin
      // History stays high until the sync chain holds real samples, so a button
      // held through reset never looks like a fresh press.
      fill_d  = {fill_q[SYNC_LAT-3:0], 1'b1};
      hist_d  = fill_q[SYNC_LAT-2] ? sync2_q : 1'b1;
      rise    = sync2_q & ~hist_q;
      fire    = REPEAT_EN && arm_q && sync2_q && (cnt_q == (rep_q ? REP_END : HOLD_END));
      pulse_d = (rise | fire) & ~clr;
      arm_d   = REPEAT_EN && sync2_q && !clr && (arm_q || rise);
      rep_d   = arm_d && (rep_q || fire);
      cnt_d   = (!arm_d || rise || fire) ? '0 : cnt_q + W'(1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         hist_q  <= 1'b1;
         fill_q  <= '0;
         pulse_q <= 1'b0;
         arm_q   <= 1'b0;
         rep_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pulse_q <= pulse_d;
         arm_q   <= arm_d;
         rep_q   <= rep_d;
         cnt_q   <= cnt_d;
      end
   end
   assign pulse = pulse_q;
endmodule

// File: rtl/clock_ctrl.sv
// clock_ctrl: mode FSM, 1 Hz tick, increment commands and blink for the clock counters
// Ports: clk; rst (async, active high); btn_mode, btn_inc (debounced, async levels);
//        mode (clk_mode_e); sec_tick, inc_min, inc_sec (one-cycle pulses); blink
module clock_ctrl
   import clock_pkg::*;
#(
   parameter int TICK_DIV   = 50_000_000,
   parameter int HOLD_CYC   = 25_000_000,
   parameter int REPEAT_CYC = 5_000_000
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      btn_mode,
   input  logic      btn_inc,
   output clk_mode_e mode,
   output logic      sec_tick,
   output logic      inc_min,
   output logic      inc_sec,
   output logic      blink
);
   localparam int PW = $clog2(TICK_DIV);
   localparam int HALF = TICK_DIV / 2;
   localparam int BW = $clog2(HALF);
   localparam logic [PW-1:0] PRE_END = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] HALF_END = BW'(HALF - 1);
   clk_mode_e mode_q, mode_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic sec_tick_q, sec_tick_d, inc_min_q, inc_min_d, inc_sec_q, inc_sec_d, blink_q, blink_d;
   logic m_pulse, i_pulse, run, restart;
   clock_btn_sync #(.REPEAT_EN(1'b0), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_mode (
      .clk(clk), .rst(rst), .btn(btn_mode), .clr(1'b0), .pulse(m_pulse)
   );
   // Every mode change resets the inc repeat machinery so a held key stays inert.
   clock_btn_sync #(.REPEAT_EN(1'b1), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_inc (
      .clk(clk), .rst(rst), .btn(btn_inc), .clr(m_pulse), .pulse(i_pulse)
   );
   always_comb begin
      run        = (mode_q == MODE_RUN);
      mode_d     = m_pulse ? next_mode(mode_q)
                 : (mode_q == MODE_SET_MIN || mode_q == MODE_SET_SEC) ? mode_q : MODE_RUN;
      // Prescaler sits at 0 outside RUN so the first tick lands TICK_DIV cycles after entry.
      pre_d      = (!run || pre_q == PRE_END) ? '0 : pre_q + PW'(1);
      sec_tick_d = run && mode_d == MODE_RUN && pre_q == PRE_END;
      inc_min_d  = i_pulse && !m_pulse && mode_q == MODE_SET_MIN;
      inc_sec_d  = i_pulse && !m_pulse && mode_q == MODE_SET_SEC;
      restart    = m_pulse || inc_min_d || inc_sec_d;
      blink_d    = (mode_d == MODE_RUN) ? 1'b0 : restart ? 1'b1
                 : (bcnt_q == HALF_END) ? ~blink_q : blink_q;
      bcnt_d     = (mode_d == MODE_RUN || restart || bcnt_q == HALF_END) ? '0 : bcnt_q + BW'(1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q     <= MODE_RUN;
         pre_q      <= '0;
         bcnt_q     <= '0;
         sec_tick_q <= 1'b0;
         inc_min_q  <= 1'b0;
         inc_sec_q  <= 1'b0;
         blink_q    <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         pre_q      <= pre_d;
         bcnt_q     <= bcnt_d;
         sec_tick_q <= sec_tick_d;
         inc_min_q  <= inc_min_d;
         inc_sec_q  <= inc_sec_d;
         blink_q    <= blink_d;
      end
   end
   assign mode     = mode_q;
   assign sec_tick = sec_tick_q;
   assign inc_min  = inc_min_q;
   assign inc_sec  = inc_sec_q;
   assign blink    = blink_q;
endmodule

// File: tb/tb_clock_ctrl.sv
// tb_clock_ctrl: randomized and directed scoreboard bench for clock_ctrl
module tb_clock_ctrl;
   import clock_pkg::*;
   localparam int TD = 10, HOLD = 8, REP = 3;
   typedef struct {
      int n;
      logic [1:0] mode;
      logic tick, imin, isec, blink;
   } ev_t;
   logic clk = 1'b0, rst = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
   logic [1:0] mode;
   logic sec_tick, inc_min, inc_sec, blink;
   ev_t q[$];
   int checks = 0, failures = 0;
   int cyc = 0;
   // reference model state
   bit sm[5], si[5];
   int mode_m = 0, t = 0, chg_n = -10, run_n = 0, rs_n = 0;
   bit armed = 0, lb = 0;
   int lm = 0;

   clock_ctrl #(.TICK_DIV(TD), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
      .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
      .mode(mode), .sec_tick(sec_tick), .inc_min(inc_min), .inc_sec(inc_sec), .blink(blink)
   );

   always #5 clk = ~clk;

   // Behavioural model: a press is seen SYNC_LAT edges after its first high sample;
   // samples before reset count as held.
   task automatic model_step();
      bit rm, ri, lvl, fire, tick, imin, isec, blk;
      int prev;
      ev_t e;
      if (rst) begin
         cyc = 0;
         foreach (sm[k]) begin sm[k] = 1; si[k] = 1; end
         mode_m = 0; armed = 0; t = 0; chg_n = -10; run_n = 0; rs_n = 0; lm = 0; lb = 0;
         return;
      end
      cyc++;
      for (int k = 4; k > 0; k--) begin sm[k] = sm[k-1]; si[k] = si[k-1]; end
      sm[0] = btn_mode;
      si[0] = btn_inc;
      rm = sm[SYNC_LAT] && !sm[SYNC_LAT+1];
      ri = si[SYNC_LAT] && !si[SYNC_LAT+1] && cyc != chg_n + 1;
      lvl = si[SYNC_LAT];
      prev = mode_m;
      fire = 0;
      if (rm) begin
         mode_m = (mode_m + 1) % 3; armed = 0; chg_n = cyc;
      end else if (ri) begin
         armed = 1; t = 0; fire = 1;
      end else if (armed && lvl) begin
         t++;
         fire = (t >= HOLD) && ((t - HOLD) % REP == 0);
      end
      if (!lvl) armed = 0;
      imin = fire && prev == 1;
      isec = fire && prev == 2;
      if (mode_m == 0 && prev != 0) run_n = cyc;
      tick = prev == 0 && mode_m == 0 && cyc > run_n && (cyc - run_n) % TD == 0;
      if (rm || imin || isec) rs_n = cyc;
      blk = mode_m != 0 && ((cyc - rs_n) / (TD / 2)) % 2 == 0;
      if (tick || imin || isec || mode_m != lm || blk != lb) begin
         e.n = cyc; e.mode = 2'(mode_m); e.tick = tick; e.imin = imin; e.isec = isec; e.blink = blk;
         q.push_back(e);
      end
      lm = mode_m;
      lb = blk;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Monitor: every visible DUT event pops the next expected event.
   initial begin
      logic [1:0] pm = 2'd0;
      logic pb = 1'b0;
      ev_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (q.size() != 0) begin
               checks++; failures++;
               $display("FAIL pending_at_reset: %0d expected events never seen", q.size());
               q.delete();
            end
            pm = 2'd0; pb = 1'b0;
            continue;
         end
         while (q.size() != 0 && q[0].n < cyc) begin
            checks++; failures++;
            e = q.pop_front();
            $display("FAIL missed_event: expected at n=%0d mode=%0d tick=%0b imin=%0b isec=%0b blink=%0b, got nothing by n=%0d",
                     e.n, e.mode, e.tick, e.imin, e.isec, e.blink, cyc);
         end
         if (sec_tick || inc_min || inc_sec || mode != pm || blink != pb) begin
            checks++;
            if (q.size() == 0) begin
               failures++;
               $display("FAIL extra_event: n=%0d mode=%0d tick=%0b imin=%0b isec=%0b blink=%0b, expected none",
                        cyc, mode, sec_tick, inc_min, inc_sec, blink);
            end else begin
               e = q.pop_front();
               if (e.n != cyc || e.mode !== mode || e.tick !== sec_tick || e.imin !== inc_min ||
                   e.isec !== inc_sec || e.blink !== blink) begin
                  failures++;
                  $display("FAIL event: got n=%0d mode=%0d tick=%0b imin=%0b isec=%0b blink=%0b, want n=%0d mode=%0d tick=%0b imin=%0b isec=%0b blink=%0b",
                           cyc, mode, sec_tick, inc_min, inc_sec, blink,
                           e.n, e.mode, e.tick, e.imin, e.isec, e.blink);
               end
            end
         end
         pm = mode;
         pb = blink;
      end
   end

   task automatic check_reset_state(input string name);
      checks++;
      if (mode !== 2'd0 || sec_tick !== 1'b0 || inc_min !== 1'b0 || inc_sec !== 1'b0 || blink !== 1'b0) begin
         failures++;
         $display("FAIL %s: mode=%0d tick=%0b imin=%0b isec=%0b blink=%0b, want all 0",
                  name, mode, sec_tick, inc_min, inc_sec, blink);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press_mode(input int h);
      @(negedge clk);
      btn_mode = 1'b1;
      repeat (h) @(negedge clk);
      btn_mode = 1'b0;
   endtask

   task automatic goto(input int m);
      for (int k = 0; k < 4 && mode_m != m; k++) begin
         press_mode(2);
         idle(8);
      end
   endtask

   // Called just after a negedge; returns 2 time units after a later negedge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1 check_reset_state("reset_immediate");
      idle(2);
      #2 rst = 1'b0;
   endtask

   initial begin
      idle(3);
      check_reset_state("power_on_reset");
      #2 rst = 1'b0;
      idle(35);
      for (int k = 0; k < 3; k++) begin
         press_mode(2);
         idle(8);
      end
      idle(25);
      goto(1);
      @(negedge clk); btn_inc = 1'b1;
      idle(20);
      btn_inc = 1'b0;
      idle(15);
      goto(2);
      @(negedge clk); btn_inc = 1'b1;
      idle(12);
      press_mode(2);
      idle(10);
      btn_inc = 1'b0;
      idle(5);
      @(negedge clk); btn_inc = 1'b1;
      idle(4);
      btn_inc = 1'b0;
      idle(10);
      goto(1);
      @(negedge clk); btn_mode = 1'b1; btn_inc = 1'b1;
      idle(2);
      btn_mode = 1'b0; btn_inc = 1'b0;
      idle(15);
      goto(2);
      @(negedge clk); btn_inc = 1'b1;
      idle(10);
      do_reset();
      idle(10);
      btn_inc = 1'b0;
      idle(5);
      goto(1);
      idle(20);
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 11) == 0) btn_mode = ~btn_mode;
         if ($urandom_range(0, 15) == 0) btn_inc = ~btn_inc;
         if ($urandom_range(0, 599) == 0) do_reset();
      end
      btn_mode = 1'b0;
      btn_inc = 1'b0;
      idle(30);
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expected events left, want 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
